// File: rtl/addsub_seq_pkg.sv
// addsub_seq_pkg
// Shared constants for the addsub_seq accumulator stage:
//   - operation encodings carried on in_op
//   - FSM state encodings used by addsub_seq
package addsub_seq_pkg;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_EXEC = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

endpackage

// File: rtl/seq_addsub_core.sv
// seq_addsub_core
// Purely combinational WIDTH-bit add/subtract datapath.
// Ports:
//   i_a      operand A (accumulator)
//   i_b      operand B
//   i_sub    0: r = a + b, 1: r = a - b (as a + ~b + 1)
//   o_r      result mod 2^WIDTH
//   o_carry  ADD: carry-out; SUB: borrow (a < b, unsigned)
//   o_ovf    two's-complement overflow
//   o_zero   o_r == 0
module seq_addsub_core #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sub,
  output logic [WIDTH-1:0] o_r,
  output logic             o_carry,
  output logic             o_ovf,
  output logic             o_zero
);

  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH:0]   w_sum;
  logic             w_a_msb;
  logic             w_b_msb;
  logic             w_r_msb;

  assign w_b_eff = i_sub ? ~i_b : i_b;
  // Carry-in of 1 completes the two's-complement negation on subtract.
  assign w_sum   = {1'b0, i_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, i_sub};

  assign o_r     = w_sum[WIDTH-1:0];
  // Carry-out of a + ~b + 1 is "no borrow", so invert it for SUB.
  assign o_carry = i_sub ? ~w_sum[WIDTH] : w_sum[WIDTH];

  assign w_a_msb = i_a[WIDTH-1];
  assign w_b_msb = i_b[WIDTH-1];
  assign w_r_msb = w_sum[WIDTH-1];

  // Sign rule uses the original b, so b = most-negative needs no special case.
  assign o_ovf   = i_sub ? ((w_a_msb != w_b_msb) && (w_r_msb != w_a_msb))
                         : ((w_a_msb == w_b_msb) && (w_r_msb != w_a_msb));

  assign o_zero  = (o_r == '0);

endmodule

// File: rtl/addsub_seq.sv
// addsub_seq
// Sequential accumulator stage: accepts one LOAD/ADD/SUB/CLR per input handshake,
// applies it to the accumulator and offers the result plus flags downstream over
// a valid/ready handshake. IDLE -> EXEC -> DONE, so at most one op per 3 cycles.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     upstream handshake (ready only in IDLE)
//   in_op, in_operand     operation and operand B (operand ignored for CLR)
//   out_valid/out_ready   downstream handshake (valid only in DONE)
//   out_data              accumulator value after the op
//   out_zero/carry/ovf    result flags
//   op_cnt                count of handed-off ops, wraps
//   sticky_ovf            sticky overflow, only when ADDSUB_SEQ_STICKY_EN is defined;
//                         otherwise tied to 0
module addsub_seq
  import addsub_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_operand,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic             out_carry,
  output logic             out_ovf,
  output logic [CNT_W-1:0] op_cnt,
  output logic             sticky_ovf
);

  logic [1:0]       r_state;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_operand;
  logic [WIDTH-1:0] r_acc;
  logic             r_zero;
  logic             r_carry;
  logic             r_ovf;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH-1:0] w_core_r;
  logic             w_core_carry;
  logic             w_core_ovf;
  logic             w_core_zero;

  logic [WIDTH-1:0] w_new_acc;
  logic             w_new_zero;
  logic             w_new_carry;
  logic             w_new_ovf;

  seq_addsub_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .i_a     (r_acc),
    .i_b     (r_operand),
    .i_sub   (r_op == OP_SUB),
    .o_r     (w_core_r),
    .o_carry (w_core_carry),
    .o_ovf   (w_core_ovf),
    .o_zero  (w_core_zero)
  );

  always_comb begin
    w_new_acc   = r_acc;
    w_new_zero  = r_zero;
    w_new_carry = 1'b0;
    w_new_ovf   = 1'b0;
    case (r_op)
      OP_LOAD: begin
        w_new_acc  = r_operand;
        w_new_zero = (r_operand == '0);
      end
      OP_ADD, OP_SUB: begin
        w_new_acc   = w_core_r;
        w_new_zero  = w_core_zero;
        w_new_carry = w_core_carry;
        w_new_ovf   = w_core_ovf;
      end
      default: begin
        w_new_acc  = '0;
        w_new_zero = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_op      <= OP_LOAD;
      r_operand <= '0;
      r_acc     <= '0;
      r_zero    <= 1'b1;
      r_carry   <= 1'b0;
      r_ovf     <= 1'b0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_op      <= in_op;
            r_operand <= in_operand;
            r_state   <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_acc   <= w_new_acc;
          r_zero  <= w_new_zero;
          r_carry <= w_new_carry;
          r_ovf   <= w_new_ovf;
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            r_cnt   <= r_cnt + CNT_W'(1);
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef ADDSUB_SEQ_STICKY_EN
  logic r_sticky;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sticky <= 1'b0;
    end else if (r_state == ST_EXEC) begin
      if (r_op == OP_CLR) begin
        r_sticky <= 1'b0;
      end else if (w_new_ovf) begin
        r_sticky <= 1'b1;
      end
    end
  end

  assign sticky_ovf = r_sticky;
`else
  assign sticky_ovf = 1'b0;
`endif

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign out_data  = r_acc;
  assign out_zero  = r_zero;
  assign out_carry = r_carry;
  assign out_ovf   = r_ovf;
  assign op_cnt    = r_cnt;

endmodule

// File: tb/tb_addsub_seq.sv
// tb_addsub_seq
// Self-checking bench for addsub_seq (WIDTH=4, CNT_W=8). Expected values come from
// an arithmetic model of the accumulator using signed/unsigned integer math.
module tb_addsub_seq;

  localparam int W    = 4;
  localparam int CW   = 8;
  localparam int MOD  = 1 << W;
  localparam int HALF = 1 << (W - 1);
`ifdef ADDSUB_SEQ_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_op;
  logic [W-1:0]  in_operand;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_zero;
  logic          out_carry;
  logic          out_ovf;
  logic [CW-1:0] op_cnt;
  logic          sticky_ovf;

  // {in_ready, out_valid, out_data, out_zero, out_carry, out_ovf, op_cnt, sticky_ovf}
  logic [17:0]   obs;
  assign obs = {in_ready, out_valid, out_data, out_zero, out_carry, out_ovf, op_cnt, sticky_ovf};

  addsub_seq #(
    .WIDTH (W),
    .CNT_W (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_operand (in_operand),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_zero   (out_zero),
    .out_carry  (out_carry),
    .out_ovf    (out_ovf),
    .op_cnt     (op_cnt),
    .sticky_ovf (sticky_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int m_acc    = 0;
  int m_cnt    = 0;
  bit m_z      = 1'b1;
  bit m_c      = 1'b0;
  bit m_v      = 1'b0;
  bit m_sticky = 1'b0;

  task automatic model_reset();
    m_acc = 0; m_cnt = 0; m_z = 1'b1; m_c = 1'b0; m_v = 1'b0; m_sticky = 1'b0;
  endtask

  task automatic model_apply(input logic [1:0] op, input int b);
    int a, sa, sb, s;
    a  = m_acc;
    sa = (a >= HALF) ? a - MOD : a;
    sb = (b >= HALF) ? b - MOD : b;
    case (op)
      2'd0: begin m_acc = b; m_c = 1'b0; m_v = 1'b0; end
      2'd1: begin
        s     = a + b;
        m_acc = s % MOD;
        m_c   = (s >= MOD);
        m_v   = (sa + sb > HALF - 1) || (sa + sb < -HALF);
      end
      2'd2: begin
        m_acc = (a - b + MOD) % MOD;
        m_c   = (a < b);
        m_v   = (sa - sb > HALF - 1) || (sa - sb < -HALF);
      end
      default: begin m_acc = 0; m_c = 1'b0; m_v = 1'b0; end
    endcase
    m_z = (m_acc == 0);
    if (op == 2'd3) m_sticky = 1'b0;
    else if (STICKY && m_v) m_sticky = 1'b1;
  endtask

  function automatic logic [17:0] exp_done();
    return {1'b0, 1'b1, W'(m_acc), m_z, m_c, m_v, CW'(m_cnt), m_sticky};
  endfunction

  function automatic logic [17:0] exp_idle();
    return {1'b1, 1'b0, W'(m_acc), m_z, m_c, m_v, CW'(m_cnt), m_sticky};
  endfunction

  // Presents one op, waits for acceptance and for out_valid (both bounded).
  // lat counts falling edges after the accepting rising edge until out_valid is seen.
  task automatic do_op(input logic [1:0] op, input logic [W-1:0] b, output bit ok,
                       output int lat);
    ok  = 1'b0;
    lat = 0;
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_operand = b;
    for (int i = 0; i < 20 && !in_ready; i++) @(negedge clk);
    if (!in_ready) begin
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      lat++;
    end
    model_apply(op, int'(b));
  endtask

  task automatic release_out(input int hold);
    repeat (hold) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    m_cnt = (m_cnt + 1) % (1 << CW);
  endtask

  task automatic test_reset();
    n_tests++;
    if (obs !== 18'({1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0})) begin
      n_fail++; $display("FAIL reset_hold: got %h expected %h", obs, exp_idle());
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (obs !== exp_idle()) begin
      n_fail++; $display("FAIL reset_release: got %h expected %h", obs, exp_idle());
    end
  endtask

  task automatic test_reset_mid_exec();
    bit ok; int lat;
    do_op(2'd0, 4'd5, ok, lat);
    release_out(0);
    @(negedge clk);
    in_valid = 1'b1; in_op = 2'd1; in_operand = 4'd3;
    @(posedge clk);
    #1 rst_n = 1'b0; in_valid = 1'b0;
    #2 rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    n_tests++;
    if (obs !== 18'({1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0})) begin
      n_fail++; $display("FAIL reset_mid_exec: got %h expected %h", obs, exp_idle());
    end
    repeat (2) @(negedge clk);
    n_tests++;
    if (obs !== exp_idle()) begin
      n_fail++; $display("FAIL reset_mid_exec_settle: got %h expected %h", obs, exp_idle());
    end
  endtask

  task automatic test_load_add_ovf();
    bit ok; int lat;
    do_op(2'd0, 4'd7, ok, lat);
    n_tests++;
    if (!ok || lat !== 2) begin
      n_fail++; $display("FAIL latency: got ok=%0d lat=%0d expected ok=1 lat=2", ok, lat);
    end
    n_tests++;
    if (obs !== exp_done()) begin
      n_fail++; $display("FAIL load7: got %h expected %h", obs, exp_done());
    end
    release_out(0);
    do_op(2'd1, 4'd1, ok, lat);
    n_tests++;
    if (!ok || {out_data, out_zero, out_carry, out_ovf} !== 7'b1000_0_0_1) begin
      n_fail++; $display("FAIL add_ovf: got %b expected 1000001",
                         {out_data, out_zero, out_carry, out_ovf});
    end
    release_out(0);
    n_tests++;
    if (op_cnt !== 8'd2) begin
      n_fail++; $display("FAIL op_cnt_two: got %0d expected 2", op_cnt);
    end
  endtask

  task automatic test_sub_most_neg();
    bit ok; int lat;
    do_op(2'd0, 4'd0, ok, lat);
    release_out(0);
    do_op(2'd2, 4'b1000, ok, lat);
    n_tests++;
    if (!ok || {out_data, out_zero, out_carry, out_ovf} !== 7'b1000_0_1_1) begin
      n_fail++; $display("FAIL sub_most_neg: got %b expected 1000011",
                         {out_data, out_zero, out_carry, out_ovf});
    end
    n_tests++;
    if (obs !== exp_done()) begin
      n_fail++; $display("FAIL sub_most_neg_model: got %h expected %h", obs, exp_done());
    end
    release_out(1);
  endtask

  task automatic test_wrap_carry();
    bit ok; int lat;
    do_op(2'd0, 4'd15, ok, lat);
    release_out(0);
    do_op(2'd1, 4'd1, ok, lat);
    n_tests++;
    if (!ok || {out_data, out_zero, out_carry, out_ovf} !== 7'b0000_1_1_0) begin
      n_fail++; $display("FAIL add_wrap: got %b expected 0000110",
                         {out_data, out_zero, out_carry, out_ovf});
    end
    release_out(0);
  endtask

  task automatic test_back_to_back_stall();
    bit ok; int lat;
    logic [17:0] snap;
    do_op(2'd0, 4'd6, ok, lat);
    release_out(0);
    do_op(2'd1, 4'd5, ok, lat);
    snap = exp_done();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid   = ~in_valid;
      in_op      = 2'($urandom_range(0, 3));
      in_operand = 4'($urandom_range(0, 15));
      n_tests++;
      if (obs !== snap) begin
        n_fail++; $display("FAIL stall_hold%0d: got %h expected %h", i, obs, snap);
      end
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    m_cnt = (m_cnt + 1) % (1 << CW);
    n_tests++;
    if (obs !== exp_idle()) begin
      n_fail++; $display("FAIL stall_release: got %h expected %h", obs, exp_idle());
    end
    // Accumulator must be untouched by the ignored requests.
    do_op(2'd1, 4'd0, ok, lat);
    n_tests++;
    if (!ok || obs !== exp_done()) begin
      n_fail++; $display("FAIL stall_no_accept: got %h expected %h", obs, exp_done());
    end
    release_out(0);
  endtask

  task automatic test_sticky();
    bit ok; int lat;
    logic [1:0] ops [6];
    logic [3:0] bs  [6];
    bit         exp_s [6];
    ops = '{2'd3, 2'd0, 2'd1, 2'd1, 2'd0, 2'd3};
    bs  = '{4'd0, 4'd7, 4'd1, 4'd0, 4'd3, 4'd0};
    exp_s = '{1'b0, 1'b0, STICKY, STICKY, STICKY, 1'b0};
    for (int i = 0; i < 6; i++) begin
      do_op(ops[i], bs[i], ok, lat);
      n_tests++;
      if (!ok || sticky_ovf !== exp_s[i]) begin
        n_fail++; $display("FAIL sticky_step%0d: got %b expected %b", i, sticky_ovf, exp_s[i]);
      end
      release_out(0);
    end
  endtask

  task automatic test_random();
    bit ok; int lat;
    logic [1:0] op;
    logic [3:0] b;
    int bad = 0;
    for (int i = 0; i < 300; i++) begin
      op = 2'($urandom_range(0, 3));
      b  = 4'($urandom_range(0, 15));
      do_op(op, b, ok, lat);
      n_tests++;
      if (!ok || lat !== 2 || obs !== exp_done()) begin
        n_fail++;
        if (bad < 10) $display("FAIL rand_op%0d op=%0d b=%0d: got %h lat=%0d expected %h",
                               i, op, b, obs, lat, exp_done());
        bad++;
      end
      release_out(int'($urandom_range(0, 2)));
      n_tests++;
      if (obs !== exp_idle()) begin
        n_fail++;
        if (bad < 10) $display("FAIL rand_idle%0d: got %h expected %h", i, obs, exp_idle());
        bad++;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_op      = 2'd0;
    in_operand = '0;
    out_ready  = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    test_reset();
    test_reset_mid_exec();
    test_load_add_ovf();
    test_sub_most_neg();
    test_wrap_carry();
    test_back_to_back_stall();
    test_sticky();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
